// File: rtl/cpc_snapshot_upload_pkg.sv
// Purpose : shared types, SNA header constants and header byte function for the snapshot upload path.
// Latency : n/a (package only).
// Backpressure: n/a.
package cpc_snap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LAUNCH,
        ST_FETCH,
        ST_DONE
    } snap_state_t;

    // First character sits in the most significant byte.
    localparam logic [63:0] SNA_SIG       = "MV - SNA";
    localparam logic [7:0]  SNA_VER_OFS   = 8'h10;
    localparam logic [7:0]  SNA_SIZE_OFS  = 8'h6B;
    localparam logic [7:0]  SNA_MODEL_OFS = 8'h6D;

    // One byte of the SNA v3 header; everything not listed is zero.
    function automatic logic [7:0] sna_hdr_byte(input logic [7:0] addr, input logic ram64k);
        logic [7:0] b;
        b = 8'h00;
        if (addr < 8'd8) begin
            b = SNA_SIG[8*(7 - int'(addr[2:0])) +: 8];
        end else if (addr == SNA_VER_OFS) begin
            b = 8'h03;
        end else if (addr == SNA_SIZE_OFS) begin
            b = ram64k ? 8'h40 : 8'h80;
        end else if (addr == SNA_MODEL_OFS) begin
            b = ram64k ? 8'h01 : 8'h02;
        end
        return b;
    endfunction

endpackage

// File: rtl/cpc_snapshot_upload_if.sv
// Purpose : ioctl upload channel plus SDRAM read port of the snapshot uploader.
// Latency : n/a (wiring only). slave = uploader, master = HPS/SDRAM side.
// Backpressure: ioctl_wait stalls the HPS; the SDRAM port is paced by ce_ref outside this bundle.
interface cpc_snapshot_upload_if;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        mem_rd;
    logic [22:0] mem_addr;
    logic [1:0]  mem_bank;
    logic [7:0]  mem_din;

    modport slave (
        input  ioctl_upload, ioctl_rd, ioctl_addr, mem_din,
        output ioctl_din, ioctl_wait, mem_rd, mem_addr, mem_bank
    );

    modport master (
        output ioctl_upload, ioctl_rd, ioctl_addr, mem_din,
        input  ioctl_din, ioctl_wait, mem_rd, mem_addr, mem_bank
    );
endinterface

// File: rtl/cpc_snapshot_upload_sna_header_rom.sv
// Purpose : registered SNA header byte lookup (clk_i, reset_i, addr_i, ram64k_i -> dat_o).
// Latency : 1 cycle from addr_i to dat_o.
// Backpressure: none; free-running lookup, the caller picks the cycle it needs.
module sna_header_rom
    import cpc_snap_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] addr_i,
    input  logic       ram64k_i,
    output logic [7:0] dat_o
);
    logic [7:0] dat_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dat_q <= 8'h00;
        end else begin
            dat_q <= sna_hdr_byte(addr_i, ram64k_i);
        end
    end

    assign dat_o = dat_q;
endmodule

// File: rtl/cpc_snapshot_upload.sv
// Purpose : serves HPS upload reads from a generated SNA header or from CPC RAM in SDRAM.
// Latency : header 2 cycles; RAM 1 + next ce_ref + (MEM_LAT-1) ce_ref + 1 cycles; out-of-range 1 cycle.
// Backpressure: ioctl_wait high while a byte is pending; reads outside IDLE are dropped.
// Ports: clk_sys/reset, ce_ref pacing, ram64k/model config, bus (ioctl + SDRAM), busy for SDRAM muxing.
module cpc_snapshot_upload
    import cpc_snap_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int HDR_LEN = 256
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ce_ref,
    input  logic                 ram64k,
    input  logic                 model,
    cpc_snapshot_upload_if.slave bus,
    output logic                 busy
);
    localparam int CW = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

    snap_state_t state_q, state_d;
    logic        wait_q, wait_d;
    logic [7:0]  din_q, din_d;
    logic [22:0] maddr_q, maddr_d;
    logic [1:0]  mbank_q, mbank_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        upload_q;
    logic        size64_q;

    logic        size64;
    logic [24:0] img_lim;
    logic        is_hdr;
    logic        is_ram;
    logic [16:0] ofs;
    logic [7:0]  hdr_dat;
    logic        fetch_last;

    // Size is captured on the session's rising edge; on that very cycle use the live pin.
    assign size64  = (bus.ioctl_upload && !upload_q) ? ram64k : size64_q;
    assign img_lim = size64 ? 25'(HDR_LEN + 65536) : 25'(HDR_LEN + 131072);
    assign is_hdr  = bus.ioctl_addr < 25'(HDR_LEN);
    assign is_ram  = !is_hdr && (bus.ioctl_addr < img_lim);
    assign ofs     = 17'(bus.ioctl_addr - 25'(HDR_LEN));

    // The ROM registers every cycle, so its output is ready exactly in HDR.
    sna_header_rom u_hdr (
        .clk_i    (clk_sys),
        .reset_i  (reset),
        .addr_i   (bus.ioctl_addr[7:0]),
        .ram64k_i (size64),
        .dat_o    (hdr_dat)
    );

    // The launch pulse is the first; data is sampled on the MEM_LAT-th pulse.
    assign fetch_last = (MEM_LAT == 1) || (ce_ref && (cnt_q == CW'(MEM_LAT - 2)));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        din_d   = din_q;
        maddr_d = maddr_q;
        mbank_d = mbank_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.ioctl_upload && bus.ioctl_rd) begin
                    if (is_hdr) begin
                        state_d = ST_HDR;
                        wait_d  = 1'b1;
                    end else if (is_ram) begin
                        state_d = ST_LAUNCH;
                        wait_d  = 1'b1;
                        maddr_d = {6'd0, ofs};
                        mbank_d = {1'b0, model};
                    end else begin
                        din_d = 8'hFF;
                    end
                end
            end
            ST_HDR: begin
                din_d   = hdr_dat;
                wait_d  = 1'b0;
                state_d = ST_DONE;
            end
            ST_LAUNCH: begin
                if (ce_ref) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end
            end
            ST_FETCH: begin
                if (fetch_last) begin
                    din_d   = bus.mem_din;
                    wait_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (ce_ref) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Session abort wins over any in-flight byte; the last delivered byte stays visible.
        if (!bus.ioctl_upload && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            wait_d  = 1'b0;
            din_d   = din_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wait_q   <= 1'b0;
            din_q    <= 8'h00;
            maddr_q  <= '0;
            mbank_q  <= '0;
            cnt_q    <= '0;
            upload_q <= 1'b0;
            size64_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            din_q    <= din_d;
            maddr_q  <= maddr_d;
            mbank_q  <= mbank_d;
            cnt_q    <= cnt_d;
            upload_q <= bus.ioctl_upload;
            size64_q <= size64;
        end
    end

    assign bus.ioctl_din  = din_q;
    assign bus.ioctl_wait = wait_q;
    assign bus.mem_rd     = (state_q == ST_LAUNCH);
    assign bus.mem_addr   = maddr_q;
    assign bus.mem_bank   = mbank_q;
    assign busy           = (state_q != ST_IDLE);
endmodule
